muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Iterative signed MULT/DIV unit plus its sequencing FSM, driven by CONTROL via
//   start/MDcontrol. Owns the HI/LO registers read by MFHI/MFLO. Raises Div0 for
//   the exception path. One result bit per cycle; a single op in flight.
// PARAMETERS
//   WIDTH    32            operand width; HI/LO are WIDTH bits each
//   CNT_W    $clog2(WIDTH) iteration counter width (derived, do not override)
// PORTS
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   start      in   1      request; sampled only in IDLE
//   MDcontrol  in   1      0 = MULT, 1 = DIV; sampled with start
//   op_a       in   WIDTH  rs: multiplicand / dividend, signed
//   op_b       in   WIDTH  rt: multiplier / divisor, signed
//   busy       out  1      high in RUN, FIX, DONE
//   done       out  1      one-cycle pulse: op finished (incl. Div0 abort)
//   HILOWrite  out  1      one-cycle pulse: HI/LO updated this cycle
//   Div0       out  1      high with done when DIV had op_b == 0
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, HILOWrite, Div0 = 0; hi = lo = 0; counter = 0.
//   Reset mid-op: abandon op, apply reset values; no done is emitted.
//   FSM states: IDLE, RUN, FIX, DONE.
//   IDLE: at edge E with start=1, latch op, |op_a|, |op_b|, and the result signs.
//     DIV with op_b==0 -> DONE; that cycle done=1, Div0=1, HILOWrite=0,
//     hi/lo unchanged.
//     Otherwise -> RUN, counter=0.
//   RUN: one iteration per cycle, counter+1; at counter==WIDTH-1 -> FIX.
//     MULT: shift-add on magnitudes into a 2*WIDTH accumulator.
//     DIV: restoring divide on magnitudes; remainder WIDTH+1 bits.
//   FIX: apply signs, then -> DONE.
//     MULT: negate 64-bit product if sign(a)^sign(b).
//     DIV: negate quotient if sign(a)^sign(b); remainder takes sign of op_a.
//   DONE: hi/lo hold final values; done=1, HILOWrite=1, Div0=0. Next edge -> IDLE.
//   Latency: start sampled at E; done high in cycle after edge E+WIDTH+1
//     (34 cycles for WIDTH=32). Div0 abort: done in cycle after E (1 cycle).
//   Results:
//     MULT: {hi,lo} = signed 64-bit product.
//     DIV: lo = quotient truncated toward zero; hi = remainder.
//     -2^31 / -1: lo = 0x80000000, hi = 0, no flag (wraps, MIPS-undefined case).
//   Handshake:
//     start ignored while busy; no queuing.
//     op_a/op_b/MDcontrol need only be valid at E.
//     done and HILOWrite are never high for 2 consecutive cycles.
//   hi/lo change only on the DONE cycle (or reset); MFHI/MFLO during busy read
//     the previous op's values.
// TESTING
//   MULT 7 x -3 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, HILOWrite pulse.
//   DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF
//     -> lo=0x80000000, hi=0.
//   DIV 5 / 0 (hi,lo preset 0x11/0x22) -> next cycle done=1, Div0=1,
//     HILOWrite=0; hi/lo stay 0x11/0x22.
//   MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0; a 2nd start at
//     cycle 10 is ignored (exactly one done).
//   Start DIV 100/7, assert reset at cycle 15 -> busy=0, hi=lo=0 next cycle;
//     no done; new MULT 3x4 -> lo=12.
//   Back-to-back: start asserted in the cycle after done -> accepted; second
//     result correct.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit with its sequencing FSM.
// Produces one result bit per cycle and owns the HI/LO result registers.
// Only one operation is in flight at a time. A divide by zero aborts
// immediately with Div0 and leaves HI/LO unchanged.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    MDcontrol,
    input  logic signed [WIDTH-1:0] op_a,
    input  logic signed [WIDTH-1:0] op_b,
    output logic                    busy,
    output logic                    done,
    output logic                    HILOWrite,
    output logic                    Div0,
    output logic [WIDTH-1:0]        hi,
    output logic [WIDTH-1:0]        lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;

    // Operation context captured at the accepting edge
    logic               is_div;
    logic               neg_main;    // negate product / quotient
    logic               neg_rem;     // remainder follows the dividend sign
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // MULT: {partial product, remaining multiplier bits}
    // DIV:  low half holds the dividend shifting out / quotient shifting in
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    // Magnitude of a two's-complement word; the most negative value maps to
    // its correct unsigned magnitude because the negation wraps.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg_word(input logic [WIDTH-1:0] x,
                                                       input logic neg);
        return neg ? WIDTH'(-x) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_dword(input logic [2*WIDTH-1:0] x,
                                                          input logic neg);
        return neg ? (2*WIDTH)'(-x) : x;
    endfunction

    // One iteration of shift-add multiply and of restoring divide
    always_comb begin
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        mult_next = {mult_sum, acc[WIDTH-1:1]};
        div_shift = {rem, acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = (div_shift >= {1'b0, mag_b});
    end

    // Datapath registers: loaded on acceptance, iterated in RUN
    always_ff @(posedge clock) begin
        case (state)
            IDLE: begin
                if (start) begin
                    is_div   <= MDcontrol;
                    neg_main <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    neg_rem  <= op_a[WIDTH-1];
                    mag_a    <= magnitude(op_a);
                    mag_b    <= magnitude(op_b);
                    rem      <= '0;
                    acc      <= MDcontrol ? {{WIDTH{1'b0}}, magnitude(op_a)}
                                          : {{WIDTH{1'b0}}, magnitude(op_b)};
                end
            end
            RUN: begin
                if (is_div) begin
                    rem <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
                end else begin
                    acc <= mult_next;
                end
            end
            default: ;
        endcase
    end

    // Sequencing FSM with registered handshake outputs and HI/LO update
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            HILOWrite <= 1'b0;
            Div0      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (MDcontrol && (op_b == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            Div0  <= 1'b1;
                        end else begin
                            state <= RUN;
                            count <= '0;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        lo <= cond_neg_word(acc[WIDTH-1:0], neg_main);
                        hi <= cond_neg_word(rem, neg_rem);
                    end else begin
                        {hi, lo} <= cond_neg_dword(acc, neg_main);
                    end
                    state     <= DONE;
                    done      <= 1'b1;
                    HILOWrite <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    HILOWrite <= 1'b0;
                    Div0      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed MULT/DIV results,
// latency, divide-by-zero abort, ignored restart, mid-op reset, back-to-back.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic                MDcontrol;
    logic signed [W-1:0] op_a;
    logic signed [W-1:0] op_b;
    logic                busy;
    logic                done;
    logic                HILOWrite;
    logic                Div0;
    logic [W-1:0]        hi;
    logic [W-1:0]        lo;

    int checks = 0;
    int errors = 0;
    int lat;
    int dones;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .MDcontrol (MDcontrol),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .HILOWrite (HILOWrite),
        .Div0      (Div0),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
    // Leaves the bench in the done cycle; lat = 0 on timeout.
    task automatic run_op(input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int restart_at, output int lat_o);
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        prev_hi   = hi;
        prev_lo   = lo;
        MDcontrol = md;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        tick;
        start     = 1'b0;
        MDcontrol = ~md;
        op_a      = 32'hDEADBEEF;
        op_b      = 32'h0;
        lat_o     = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n == restart_at) begin
                start     = 1'b1;
                MDcontrol = 1'b1;
                op_b      = 32'h0;
            end else begin
                start = 1'b0;
            end
            if (n == 5) begin
                check("busy_mid", busy, 1);
                check("hilo_hold_mid", {hi, lo}, {prev_hi, prev_lo});
            end
            if (done) begin
                lat_o = n;
                break;
            end
            tick;
        end
        start = 1'b0;
        if (lat_o == 0) check("done_timeout", 0, 1);
    endtask

    // Cycle after done: pulses gone, unit idle
    task automatic after_done(input string tag);
        tick;
        check({tag, "_done_low"}, done, 0);
        check({tag, "_hlw_low"}, HILOWrite, 0);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_div0_low"}, Div0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        MDcontrol = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) tick;
        reset = 1'b0;
        tick;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hlw", HILOWrite, 0);
        check("rst_div0", Div0, 0);
        check("rst_hilo", {hi, lo}, 64'h0);

        // MULT 7 x -3 = -21
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 0, lat);
        check("mul1_lat", lat, 34);
        check("mul1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        check("mul1_hlw", HILOWrite, 1);
        check("mul1_div0", Div0, 0);
        check("mul1_busy", busy, 1);
        after_done("mul1");

        // DIV -7 / 2 -> q=-3, r=-1
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, lat);
        check("div1_lat", lat, 34);
        check("div1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        check("div1_hlw", HILOWrite, 1);
        after_done("div1");

        // DIV -2^31 / -1 wraps
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, lat);
        check("div2_lat", lat, 34);
        check("div2_hilo", {hi, lo}, 64'h00000000_80000000);
        check("div2_div0", Div0, 0);
        after_done("div2");

        // Preset hi/lo to 0x11/0x22 via 0x451 / 0x20 (q=34, r=17)
        run_op(1'b1, 32'h451, 32'h20, 0, lat);
        check("preset_hilo", {hi, lo}, 64'h00000011_00000022);
        after_done("preset");

        // DIV 5 / 0 aborts in one cycle
        run_op(1'b1, 32'd5, 32'd0, 0, lat);
        check("dz_lat", lat, 1);
        check("dz_div0", Div0, 1);
        check("dz_hlw", HILOWrite, 0);
        check("dz_busy", busy, 1);
        check("dz_hilo", {hi, lo}, 64'h00000011_00000022);
        after_done("dz");
        check("dz_hilo_after", {hi, lo}, 64'h00000011_00000022);

        // MULT -2^31 x -2^31 with an ignored restart at cycle 10
        run_op(1'b0, 32'h80000000, 32'h80000000, 10, lat);
        check("mul2_lat", lat, 34);
        check("mul2_hilo", {hi, lo}, 64'h40000000_00000000);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (done) dones++;
        end
        check("mul2_single_done", dones, 0);
        check("mul2_idle", busy, 0);

        // Reset during DIV 100 / 7 at cycle 15
        MDcontrol = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd7;
        start     = 1'b1;
        tick;
        start = 1'b0;
        repeat (14) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_hilo", {hi, lo}, 64'h0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || HILOWrite) dones++;
            tick;
        end
        check("mrst_no_done", dones, 0);
        run_op(1'b0, 32'd3, 32'd4, 0, lat);
        check("mrst_mul_lat", lat, 34);
        check("mrst_mul_hilo", {hi, lo}, 64'h00000000_0000000C);
        after_done("mrst");

        // Back-to-back: DIV 100/7, then MULT -5 x 6 started the cycle after done
        run_op(1'b1, 32'd100, 32'd7, 0, lat);
        check("b2b1_hilo", {hi, lo}, 64'h00000002_0000000E);
        tick;
        run_op(1'b0, 32'hFFFFFFFB, 32'd6, 0, lat);
        check("b2b2_lat", lat, 34);
        check("b2b2_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFE2);
        after_done("b2b2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
